dlfloat_addsub_pipe: RTL

//  Parametrised, pipelined floating-point add/subtract unit for the DLfloat datapath.

---
 rtl/dlfloat_addsub_pipe_if.sv | 32 +++
 rtl/dlfloat_addsub_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dlfloat_addsub_pipe_if.sv
// Operand/result bundle for the DLfloat add/subtract pipeline.
// Handshake: a beat moves on a rising edge only when valid and ready are both high; valid
// never depends on ready, and a producer holds its payload stable while valid && !ready.
interface dlfloat_addsub_pipe_if #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 9,
    parameter int TAG_W = 4
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             op;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, a, b, op, tag_in, out_ready,
        input  in_ready, out_valid, result, flags, tag_out
    );

    modport slave (
        input  in_valid, a, b, op, tag_in, out_ready,
        output in_ready, out_valid, result, flags, tag_out
    );
endinterface

// File: rtl/dlfloat_addsub_pipe.sv
// Three-stage DLfloat add/subtract with round-to-nearest-even and a tag carried alongside.
// S1 aligns operands and resolves special cases, S2 adds and counts leading zeros, S3 rounds.
module dlfloat_addsub_pipe #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 9,
    parameter int TAG_W = 4
) (
    input logic                  clk,
    input logic                  rst,
    dlfloat_addsub_pipe_if.slave io
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;
    localparam int LZW = $clog2(SW + 1);
    localparam int EXW = EXP_W + 2;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = LZW'(SW);
        found = 1'b0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = LZW'(SW - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    logic adv;
    logic out_valid_q;
    logic [W-1:0] result_q;
    logic [4:0] flags_q;
    logic [TAG_W-1:0] tag_out_q;

    // The whole pipe freezes while a result waits on the consumer.
    assign adv          = !out_valid_q || io.out_ready;
    assign io.in_ready  = adv;
    assign io.out_valid = out_valid_q;
    assign io.result    = result_q;
    assign io.flags     = flags_q;
    assign io.tag_out   = tag_out_q;

    logic sa, sb, swap, a_nan, b_nan, a_zero, b_zero;
    logic [EXP_W-1:0] ea, eb, e_diff;
    logic [MAN_W-1:0] ma, mb, m_big, m_small;
    logic [SW-1:0] small_ext, small_sh, lost_mask;
    logic s1_spec_d;
    logic [W-1:0] s1_sres_d;
    logic [4:0] s1_sflags_d;

    always_comb begin
        sa        = io.a[W-1];
        ea        = io.a[W-2:MAN_W];
        ma        = io.a[MAN_W-1:0];
        sb        = io.b[W-1] ^ io.op;
        eb        = io.b[W-2:MAN_W];
        mb        = io.b[MAN_W-1:0];
        a_nan     = &io.a[W-2:0];
        b_nan     = &io.b[W-2:0];
        a_zero    = (ea == '0);
        b_zero    = (eb == '0);
        swap      = {eb, mb} > {ea, ma};
        e_diff    = swap ? (eb - ea) : (ea - eb);
        m_big     = swap ? mb : ma;
        m_small   = swap ? ma : mb;
        small_ext = {1'b1, m_small, 3'b000};
        small_sh  = '0;
        lost_mask = '0;
        // Anything shifted past the sticky position collapses into a lone sticky bit.
        if ({{(32-EXP_W){1'b0}}, e_diff} >= 32'(MAN_W + 3)) begin
            small_sh = SW'(1);
        end else begin
            lost_mask   = ~({SW{1'b1}} << e_diff);
            small_sh    = small_ext >> e_diff;
            small_sh[0] = small_sh[0] | (|(small_ext & lost_mask));
        end
        s1_spec_d   = 1'b1;
        s1_sres_d   = '0;
        s1_sflags_d = '0;
        if (a_nan || b_nan) begin
            s1_sres_d   = '1;
            s1_sflags_d = 5'b10000;
        end else if (a_zero && b_zero) begin
            s1_sres_d = {sa & sb, {(W-1){1'b0}}};
        end else if (a_zero) begin
            s1_sres_d = {sb, io.b[W-2:0]};
        end else if (b_zero) begin
            s1_sres_d = io.a;
        end else begin
            s1_spec_d = 1'b0;
        end
    end

    logic s1_valid_q, s1_spec_q, s1_sign_q, s1_sub_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [W-1:0] s1_sres_q;
    logic [4:0] s1_sflags_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [SW-1:0] s1_big_q, s1_small_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (adv) begin
            s1_valid_q  <= io.in_valid;
            s1_tag_q    <= io.tag_in;
            s1_spec_q   <= s1_spec_d;
            s1_sres_q   <= s1_sres_d;
            s1_sflags_q <= s1_sflags_d;
            s1_sign_q   <= swap ? sb : sa;
            s1_sub_q    <= sa ^ sb;
            s1_exp_q    <= swap ? eb : ea;
            s1_big_q    <= {1'b1, m_big, 3'b000};
            s1_small_q  <= small_sh;
        end
    end

    logic [SW:0] s2_sum_d;

    always_comb begin
        if (s1_sub_q) s2_sum_d = {1'b0, s1_big_q} - {1'b0, s1_small_q};
        else          s2_sum_d = {1'b0, s1_big_q} + {1'b0, s1_small_q};
    end

    logic s2_valid_q, s2_spec_q, s2_sign_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic [W-1:0] s2_sres_q;
    logic [4:0] s2_sflags_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [SW:0] s2_sum_q;
    logic [LZW-1:0] s2_lzc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
        end else if (adv) begin
            s2_valid_q  <= s1_valid_q;
            s2_tag_q    <= s1_tag_q;
            s2_spec_q   <= s1_spec_q;
            s2_sres_q   <= s1_sres_q;
            s2_sflags_q <= s1_sflags_q;
            s2_sign_q   <= s1_sign_q;
            s2_exp_q    <= s1_exp_q;
            s2_sum_q    <= s2_sum_d;
            s2_lzc_q    <= lzc(s2_sum_d[SW-1:0]);
        end
    end

    logic [SW-1:0] norm;
    logic [EXW-1:0] exp_n, exp_f;
    logic [MAN_W+1:0] mant_r;
    logic [MAN_W-1:0] man_f;
    logic inexact, rnd_up, ovf, unf;
    logic [W-1:0] result_d;
    logic [4:0] flags_d;

    always_comb begin
        if (s2_sum_q[SW]) begin
            norm    = s2_sum_q[SW:1];
            norm[0] = s2_sum_q[1] | s2_sum_q[0];
            exp_n   = {2'b00, s2_exp_q} + EXW'(1);
        end else begin
            norm  = s2_sum_q[SW-1:0] << s2_lzc_q;
            exp_n = {2'b00, s2_exp_q} - {{(EXW-LZW){1'b0}}, s2_lzc_q};
        end
        inexact = |norm[2:0];
        rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r  = {1'b0, norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
        if (mant_r[MAN_W+1]) begin
            man_f = mant_r[MAN_W:1];
            exp_f = exp_n + EXW'(1);
        end else begin
            man_f = mant_r[MAN_W-1:0];
            exp_f = exp_n;
        end
        // exp_f is two's complement: a set top bit means the exponent went negative.
        ovf = !exp_f[EXW-1] && ((exp_f[EXW-2:EXP_W] != '0) ||
                                ((exp_f[EXP_W-1:0] == EXP_MAX) && (&man_f)));
        unf = exp_f[EXW-1] || (exp_f == '0);
        result_d = {s2_sign_q, exp_f[EXP_W-1:0], man_f};
        flags_d  = {1'b0, inexact, 3'b000};
        if (s2_spec_q) begin
            result_d = s2_sres_q;
            flags_d  = s2_sflags_q;
        end else if (s2_sum_q == '0) begin
            result_d = '0;
            flags_d  = '0;
        end else if (ovf) begin
            result_d = {s2_sign_q, EXP_MAX, {(MAN_W-1){1'b1}}, 1'b0};
            flags_d  = 5'b01100;
        end else if (unf) begin
            result_d = {s2_sign_q, {(W-1){1'b0}}};
            flags_d  = 5'b01010;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            tag_out_q   <= '0;
        end else if (adv) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                result_q  <= result_d;
                flags_q   <= flags_d;
                tag_out_q <= s2_tag_q;
            end
        end
    end
endmodule
